// File: rtl/pmp_pkg.sv
// Shared types and constants for the scanning PMP checker.
package pmp_pkg;

  // pmpcfg A-field encoding
  typedef enum logic [1:0] {
    PmpOff   = 2'd0,
    PmpTor   = 2'd1,
    PmpNa4   = 2'd2,
    PmpNapot = 2'd3
  } pmp_mode_e;

  // Bit offsets inside one 8-bit pmpcfg entry
  localparam int unsigned CfgBitR   = 0;
  localparam int unsigned CfgBitW   = 1;
  localparam int unsigned CfgBitX   = 2;
  localparam int unsigned CfgBitALo = 3;
  localparam int unsigned CfgBitL   = 7;

  typedef enum logic [1:0] {
    AccRead  = 2'd0,
    AccWrite = 2'd1,
    AccExec  = 2'd2,
    AccRsvd  = 2'd3
  } pmp_acc_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StResp = 2'd2
  } pmp_state_e;

  // Wide enough for any supported entry count; the top slices what it needs.
  localparam int unsigned MaxIdxW = 8;

  typedef struct packed {
    logic               r;
    logic               w;
    logic               x;
    logic               hit;
    logic [MaxIdxW-1:0] idx;
  } pmp_result_t;

  // Reserved access type falls back to a read check.
  function automatic logic access_allowed(pmp_acc_e acc, logic r, logic w, logic x);
    logic allow;
    case (acc)
      AccWrite: allow = w;
      AccExec:  allow = x;
      default:  allow = r;
    endcase
    return allow;
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational evaluator for one PMP entry against both ends of an access.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int unsigned PaddrBits = 32
) (
  input  logic [PaddrBits-1:0] acc_base_i,
  input  logic [PaddrBits-1:0] acc_end_i,
  input  pmp_mode_e            mode_i,
  input  logic [PaddrBits-1:0] entry_base_i,
  input  logic [PaddrBits-1:0] prev_base_i,
  input  logic [PaddrBits-1:0] mask_i,
  output logic                 hit_o,
  output logic                 partial_o
);

  logic match_base, match_end;

  function automatic logic addr_match(input logic [PaddrBits-1:0] a,
                                      input pmp_mode_e            mode,
                                      input logic [PaddrBits-1:0] base,
                                      input logic [PaddrBits-1:0] prev,
                                      input logic [PaddrBits-1:0] mask);
    logic m;
    case (mode)
      PmpTor:   m = (a >= prev) && (a < base);
      PmpNa4:   m = (a[PaddrBits-1:2] == base[PaddrBits-1:2]);
      PmpNapot: m = (((a ^ base) & ~mask) == '0);
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

  // Evaluate first and last byte independently; disagreement means the access straddles
  always_comb begin
    match_base = addr_match(acc_base_i, mode_i, entry_base_i, prev_base_i, mask_i);
    match_end  = addr_match(acc_end_i, mode_i, entry_base_i, prev_base_i, mask_i);
    hit_o      = match_base & match_end;
    partial_o  = match_base ^ match_end;
  end

endmodule

// File: rtl/pmp_scan_checker.sv
// Multi-cycle PMP checker: scans entries in groups, lowest index wins,
// returns permissions over a valid/ready response channel.
module pmp_scan_checker
  import pmp_pkg::*;
#(
  parameter int unsigned NumEntries      = 8,
  parameter int unsigned EntriesPerCycle = 2,
  parameter int unsigned PaddrBits       = 32,
  localparam int unsigned IdxW           = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [PaddrBits-1:0]              req_addr_i,
  input  logic [1:0]                        req_size_i,
  input  logic [1:0]                        req_prv_i,
  input  logic [1:0]                        req_type_i,
  input  logic [8*NumEntries-1:0]           pmp_cfg_i,
  input  logic [(PaddrBits-2)*NumEntries-1:0] pmp_addr_i,
  input  logic [PaddrBits*NumEntries-1:0]   pmp_mask_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic                              resp_r_o,
  output logic                              resp_w_o,
  output logic                              resp_x_o,
  output logic                              resp_allow_o,
  output logic                              resp_hit_o,
  output logic [IdxW-1:0]                   resp_idx_o
);

  localparam int unsigned NumGroups = NumEntries / EntriesPerCycle;
  localparam int unsigned GrpW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam int unsigned AddrW     = PaddrBits - 2;

  pmp_state_e           state_q, state_d;
  logic [PaddrBits-1:0] addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic [1:0]           prv_q, prv_d;
  pmp_acc_e             type_q, type_d;
  logic [GrpW-1:0]      grp_q, grp_d;
  pmp_result_t          res_q, res_d;

  // Per-entry views of the flattened CSR buses
  pmp_mode_e            mode_arr [NumEntries];
  logic [2:0]           perm_arr [NumEntries];
  logic                 lock_arr [NumEntries];
  logic [PaddrBits-1:0] base_arr [NumEntries];
  logic [PaddrBits-1:0] mask_arr [NumEntries];
  logic [NumEntries-1:0] unused_cfg;
  logic                 unused_idx;

  for (genvar i = 0; i < NumEntries; i++) begin : g_unpack
    assign mode_arr[i]   = pmp_mode_e'(pmp_cfg_i[8*i+CfgBitALo +: 2]);
    assign perm_arr[i]   = pmp_cfg_i[8*i+CfgBitR +: 3];
    assign lock_arr[i]   = pmp_cfg_i[8*i+CfgBitL];
    assign base_arr[i]   = {pmp_addr_i[AddrW*i +: AddrW], 2'b00};
    assign mask_arr[i]   = pmp_mask_i[PaddrBits*i +: PaddrBits];
    assign unused_cfg[i] = ^pmp_cfg_i[8*i+5 +: 2];
  end

  assign unused_idx = ^res_q.idx;

  // End address in one extra bit so a wrap past the top of memory is visible
  logic [PaddrBits:0]   acc_end_full;
  logic                 end_carry;
  logic [PaddrBits-1:0] acc_end;

  assign acc_end_full = {1'b0, addr_q} + ((PaddrBits+1)'(1) << size_q) - (PaddrBits+1)'(1);
  assign end_carry    = acc_end_full[PaddrBits];
  assign acc_end      = acc_end_full[PaddrBits-1:0];

  logic [EntriesPerCycle-1:0] ent_hit, ent_partial;
  logic [IdxW-1:0]            ent_idx  [EntriesPerCycle];
  logic [2:0]                 ent_perm [EntriesPerCycle];
  logic                       ent_lock [EntriesPerCycle];

  for (genvar j = 0; j < EntriesPerCycle; j++) begin : g_entry
    logic [IdxW-1:0]      idx, pidx;
    logic [PaddrBits-1:0] prev_base;

    assign idx         = IdxW'(32'(grp_q) * EntriesPerCycle + 32'(j));
    assign pidx        = idx - IdxW'(1);
    assign prev_base   = (idx == '0) ? '0 : base_arr[pidx];
    assign ent_idx[j]  = idx;
    assign ent_perm[j] = perm_arr[idx];
    assign ent_lock[j] = lock_arr[idx];

    pmp_entry_match #(
      .PaddrBits (PaddrBits)
    ) u_match (
      .acc_base_i   (addr_q),
      .acc_end_i    (acc_end),
      .mode_i       (mode_arr[idx]),
      .entry_base_i (base_arr[idx]),
      .prev_base_i  (prev_base),
      .mask_i       (mask_arr[idx]),
      .hit_o        (ent_hit[j]),
      .partial_o    (ent_partial[j])
    );
  end

  logic            sel_found, sel_partial, sel_lock;
  logic [2:0]      sel_perm;
  logic [IdxW-1:0] sel_idx;

  // Priority encoder: lowest index in the current group that touches the access
  always_comb begin
    sel_found   = 1'b0;
    sel_partial = 1'b0;
    sel_lock    = 1'b0;
    sel_perm    = '0;
    sel_idx     = '0;
    for (int unsigned j = 0; j < EntriesPerCycle; j++) begin
      if (!sel_found && (ent_hit[j] || ent_partial[j])) begin
        sel_found   = 1'b1;
        sel_partial = ent_partial[j];
        sel_lock    = ent_lock[j];
        sel_perm    = ent_perm[j];
        sel_idx     = ent_idx[j];
      end
    end
  end

  logic prv_is_m;
  assign prv_is_m = (prv_q > 2'd1);

  // Next-state, group counter and result capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    prv_d   = prv_q;
    type_d  = type_q;
    grp_d   = grp_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          prv_d   = req_prv_i;
          type_d  = pmp_acc_e'(req_type_i);
          grp_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (end_carry) begin
          res_d   = '0;
          state_d = StResp;
        end else if (sel_found) begin
          res_d.hit = 1'b1;
          res_d.idx = MaxIdxW'(sel_idx);
          if (sel_partial) begin
            {res_d.x, res_d.w, res_d.r} = 3'b000;
          end else if (prv_is_m && !sel_lock) begin
            {res_d.x, res_d.w, res_d.r} = 3'b111;
          end else begin
            {res_d.x, res_d.w, res_d.r} = sel_perm;
          end
          state_d = StResp;
        end else if (grp_q == GrpW'(NumGroups - 1)) begin
          res_d.hit = 1'b0;
          res_d.idx = '0;
          res_d.r   = prv_is_m;
          res_d.w   = prv_is_m;
          res_d.x   = prv_is_m;
          state_d   = StResp;
        end else begin
          grp_d = grp_q + GrpW'(1);
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          grp_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request/result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      size_q  <= '0;
      prv_q   <= '0;
      type_q  <= AccRead;
      grp_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      prv_q   <= prv_d;
      type_q  <= type_d;
      grp_q   <= grp_d;
      res_q   <= res_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_r_o     = res_q.r;
  assign resp_w_o     = res_q.w;
  assign resp_x_o     = res_q.x;
  assign resp_hit_o   = res_q.hit;
  assign resp_idx_o   = res_q.idx[IdxW-1:0];
  assign resp_allow_o = access_allowed(type_q, res_q.r, res_q.w, res_q.x);

endmodule

// File: tb/tb_pmp_scan_checker.sv
// Self-checking bench for pmp_scan_checker: directed cases plus randomized
// requests compared against an interval-based reference model.
module tb_pmp_scan_checker;

  localparam int N = 8;
  localparam int E = 2;
  localparam int P = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready;
  logic [P-1:0]    req_addr;
  logic [1:0]      req_size, req_prv, req_type;
  logic [8*N-1:0]  pmp_cfg;
  logic [30*N-1:0] pmp_addr;
  logic [32*N-1:0] pmp_mask;
  logic            resp_valid, resp_ready;
  logic            resp_r, resp_w, resp_x, resp_allow, resp_hit;
  logic [2:0]      resp_idx;

  logic [7:0]  cfg_a   [N];
  logic [29:0] paddr_a [N];
  logic [31:0] mask_a  [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    pmp_cfg  = '0;
    pmp_addr = '0;
    pmp_mask = '0;
    for (int i = 0; i < N; i++) begin
      pmp_cfg[8*i +: 8]   = cfg_a[i];
      pmp_addr[30*i +: 30] = paddr_a[i];
      pmp_mask[32*i +: 32] = mask_a[i];
    end
  end

  pmp_scan_checker #(
    .NumEntries      (N),
    .EntriesPerCycle (E),
    .PaddrBits       (P)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_size_i   (req_size),
    .req_prv_i    (req_prv),
    .req_type_i   (req_type),
    .pmp_cfg_i    (pmp_cfg),
    .pmp_addr_i   (pmp_addr),
    .pmp_mask_i   (pmp_mask),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_r_o     (resp_r),
    .resp_w_o     (resp_w),
    .resp_x_o     (resp_x),
    .resp_allow_o (resp_allow),
    .resp_hit_o   (resp_hit),
    .resp_idx_o   (resp_idx)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_a[i]   = 8'h00;
      paddr_a[i] = 30'h0;
      mask_a[i]  = 32'h0;
    end
  endtask

  // Each entry is reduced to a half-open byte interval [lo, hi); an access
  // touches an entry when its first or last byte lies inside that interval.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                input logic [1:0] prv,
                                output logic r, output logic w, output logic x,
                                output logic hit, output int idx, output int lat);
    longint unsigned s, e, lo, hi, base, prev;
    bit ins, ine, done;
    s    = longint'(a);
    e    = s + (64'd1 << sz) - 64'd1;
    done = 0;
    r = 0; w = 0; x = 0; hit = 0; idx = 0; lat = N / E + 1;
    if (e > 64'hFFFF_FFFF) begin
      lat  = 2;
      done = 1;
    end
    for (int i = 0; i < N && !done; i++) begin
      base = longint'(paddr_a[i]) * 4;
      prev = (i == 0) ? 64'd0 : longint'(paddr_a[i-1]) * 4;
      lo = 0; hi = 0;
      case (cfg_a[i][4:3])
        2'd1: begin lo = prev; hi = base; end
        2'd2: begin lo = base; hi = base + 4; end
        2'd3: begin
          lo = longint'({paddr_a[i], 2'b00} & ~mask_a[i]);
          hi = lo + longint'(mask_a[i]) + 1;
        end
        default: begin lo = 0; hi = 0; end
      endcase
      ins = (s >= lo) && (s < hi);
      ine = (e >= lo) && (e < hi);
      if (ins || ine) begin
        done = 1;
        hit  = 1;
        idx  = i;
        lat  = i / E + 2;
        if (ins && ine) begin
          if (prv > 1 && !cfg_a[i][7]) {r, w, x} = 3'b111;
          else {r, w, x} = {cfg_a[i][0], cfg_a[i][1], cfg_a[i][2]};
        end
      end
    end
    if (!done) begin
      r = (prv > 1); w = (prv > 1); x = (prv > 1);
    end
  endfunction

  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] prv,
                        input logic [1:0] ty, input int hold,
                        output logic o_allow, output logic o_hit, output logic [2:0] o_idx,
                        output int o_lat);
    logic er, ew, ex, eh, ea;
    int   ei, el, lat;
    bit   got;
    model(a, sz, prv, er, ew, ex, eh, ei, el);
    ea = (ty == 2'd1) ? ew : (ty == 2'd2) ? ex : er;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = sz;
    req_prv   = prv;
    req_type  = ty;
    @(posedge clk);
    #1;
    // Scramble request inputs after acceptance; the DUT must use latched copies
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_size  = 2'($urandom);
    req_prv   = 2'($urandom);
    req_type  = 2'($urandom);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) got = 1;
      else check("req_ready_busy", req_ready, 1'b0);
    end
    check("latency", lat, el);
    o_allow = resp_allow;
    o_hit   = resp_hit;
    o_idx   = resp_idx;
    o_lat   = lat;
    for (int h = 0; h <= hold; h++) begin
      check("resp_valid", resp_valid, 1'b1);
      check("resp_r", resp_r, er);
      check("resp_w", resp_w, ew);
      check("resp_x", resp_x, ex);
      check("resp_allow", resp_allow, ea);
      check("resp_hit", resp_hit, eh);
      check("resp_idx", resp_idx, ei);
      check("req_ready_resp", req_ready, 1'b0);
      if (h < hold) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid_drop", resp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    logic       al, hi;
    logic [2:0] ix;
    int         lt;
    logic [31:0] a;
    int          k, j;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_prv    = '0;
    req_type   = '0;
    resp_ready = 1'b0;
    clear_cfg();

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rwx", {resp_r, resp_w, resp_x}, 3'b000);
    check("rst_resp_allow", resp_allow, 1'b0);
    check("rst_resp_hit", resp_hit, 1'b0);
    check("rst_resp_idx", resp_idx, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // NAPOT 4 KiB region at 0x8000_0000, read-only, user mode
    cfg_a[0]   = 8'h19;
    paddr_a[0] = 30'h2000_0000;
    mask_a[0]  = 32'h0000_0FFF;
    do_req(32'h8000_0010, 2'd2, 2'd0, 2'd0, 0, al, hi, ix, lt);
    check("napot_rd_allow", al, 1'b1);
    check("napot_rd_hit", hi, 1'b1);
    check("napot_rd_idx", ix, 3'd0);
    check("napot_rd_lat", lt, 2);
    do_req(32'h8000_0010, 2'd2, 2'd0, 2'd1, 0, al, hi, ix, lt);
    check("napot_wr_allow", al, 1'b0);

    // Priority across groups
    clear_cfg();
    cfg_a[5]   = 8'h17;
    paddr_a[5] = 30'h400;
    cfg_a[7]   = 8'h09;
    paddr_a[7] = 30'h800;
    do_req(32'h0000_1000, 2'd2, 2'd0, 2'd0, 0, al, hi, ix, lt);
    check("prio_idx", ix, 3'd5);
    check("prio_lat", lt, 4);
    check("prio_allow", al, 1'b1);
    do_req(32'h0000_1800, 2'd2, 2'd0, 2'd1, 0, al, hi, ix, lt);
    check("tor_idx", ix, 3'd7);
    check("tor_wr_allow", al, 1'b0);
    check("tor_lat", lt, 5);

    // Partial match straddling an NA4 entry
    clear_cfg();
    cfg_a[0]   = 8'h17;
    paddr_a[0] = 30'h400;
    do_req(32'h0000_1000, 2'd3, 2'd0, 2'd0, 0, al, hi, ix, lt);
    check("partial_hit", hi, 1'b1);
    check("partial_allow", al, 1'b0);
    do_req(32'h0000_0FFE, 2'd2, 2'd3, 2'd2, 0, al, hi, ix, lt);
    check("partial_m_allow", al, 1'b0);

    // No match: M defaults open, S closed, both scan every group
    clear_cfg();
    do_req(32'h0000_4000, 2'd0, 2'd3, 2'd0, 0, al, hi, ix, lt);
    check("nomatch_m_allow", al, 1'b1);
    check("nomatch_m_hit", hi, 1'b0);
    check("nomatch_m_lat", lt, 5);
    do_req(32'h0000_4000, 2'd0, 2'd1, 2'd2, 0, al, hi, ix, lt);
    check("nomatch_s_allow", al, 1'b0);
    check("nomatch_s_lat", lt, 5);

    // Ignore rule for M with L=0, enforced once locked
    cfg_a[0]   = 8'h18;
    paddr_a[0] = 30'h2000_0000;
    mask_a[0]  = 32'h0000_0FFF;
    do_req(32'h8000_0100, 2'd2, 2'd3, 2'd1, 0, al, hi, ix, lt);
    check("ignore_allow", al, 1'b1);
    cfg_a[0] = 8'h98;
    do_req(32'h8000_0100, 2'd2, 2'd3, 2'd1, 0, al, hi, ix, lt);
    check("lock_allow", al, 1'b0);

    // Backpressure for 10 cycles
    cfg_a[0] = 8'h18;
    do_req(32'h8000_0200, 2'd1, 2'd3, 2'd2, 10, al, hi, ix, lt);
    check("bp_allow", al, 1'b1);

    // Reset pulse mid-SCAN
    clear_cfg();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    req_size  = 2'd0;
    req_prv   = 2'd3;
    req_type  = 2'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstscan_busy", req_ready, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstscan_resp_valid", resp_valid, 1'b0);
    check("rstscan_req_ready", req_ready, 1'b1);
    check("rstscan_rwx", {resp_r, resp_w, resp_x}, 3'b000);
    check("rstscan_hit", resp_hit, 1'b0);
    check("rstscan_allow", resp_allow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstscan_idle", resp_valid, 1'b0);

    // End-address overflow and the largest non-wrapping access
    do_req(32'hFFFF_FFFE, 2'd2, 2'd3, 2'd0, 0, al, hi, ix, lt);
    check("ovf_allow", al, 1'b0);
    check("ovf_hit", hi, 1'b0);
    check("ovf_lat", lt, 2);
    do_req(32'hFFFF_FFFC, 2'd2, 2'd3, 2'd0, 0, al, hi, ix, lt);
    check("top_allow", al, 1'b1);
    check("top_lat", lt, 5);

    // Randomized requests against the interval model
    for (int it = 0; it < 150; it++) begin
      if (it % 10 == 0) begin
        for (int i = 0; i < N; i++) begin
          cfg_a[i]   = {1'($urandom), 2'b00, 2'($urandom), 3'($urandom)};
          paddr_a[i] = 30'($urandom_range(0, 32'h3FFF));
          k          = $urandom_range(2, 12);
          mask_a[i]  = (32'd1 << k) - 32'd1;
        end
      end
      j = $urandom_range(0, N - 1);
      case ($urandom_range(0, 7))
        0:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1, 2:    a = 32'($urandom_range(0, 32'h10000));
        default: a = {paddr_a[j], 2'b00} + 32'($urandom_range(0, 7)) - 32'd3;
      endcase
      do_req(a, 2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 2),
             al, hi, ix, lt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_scan_checker.md
# pmp_scan_checker

Parametrised, handshaked PMP checker that succeeds the single-cycle combinational checker. It accepts one access request at a time and scans `NUM_ENTRIES` PMP entries, `ENTRIES_PER_CYCLE` per clock, with lowest index taking priority. It supports OFF/TOR/NA4/NAPOT modes and access-size-aware partial-match detection, then returns R/W/X and an allow verdict over a valid/ready response channel. It sits between the LSU/fetch address path and the CSR-held PMP state.

## Interface
- `NUM_ENTRIES`, 8, number of PMP entries; must be a multiple of `ENTRIES_PER_CYCLE`
- `ENTRIES_PER_CYCLE`, 2, entries evaluated per SCAN cycle; legal values 1, 2, 4, 8
- `PADDR_BITS`, 32, physical address width
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid` / `req_ready`  in / out  1  request handshake
- `req_addr`  in  `PADDR_BITS`  first byte of access
- `req_size`  in  2  log2 of access bytes (0..3)
- `req_prv`  in  2  privilege; M when > 1
- `req_type`  in  2  0 read, 1 write, 2 execute; 3 is reserved and treated as read
- `pmp_cfg`  in  `8*NUM_ENTRIES`  entry i at [8i+7:8i]: bit 7 L, bits 4:3 A, bit 2 X, bit 1 W, bit 0 R
- `pmp_addr`  in  `(PADDR_BITS-2)*NUM_ENTRIES`  pmpaddr per entry, word granular
- `pmp_mask`  in  `PADDR_BITS*NUM_ENTRIES`  precomputed NAPOT mask per entry
- `resp_valid` / `resp_ready`  out / in  1  response handshake
- `resp_r`, `resp_w`, `resp_x`, `resp_allow`, `resp_hit`  out  1 each  permissions, verdict, matched flag
- `resp_idx`  out  `$clog2(NUM_ENTRIES)`  matching entry (0 when `resp_hit`=0)

## Operation
- FSM states: IDLE, SCAN, RESP.
  - IDLE: `req_ready`=1. On handshake, latch addr/size/prv/type, set group index g=0, go to SCAN.
  - SCAN: evaluate entries g·E .. g·E+E−1, where E=`ENTRIES_PER_CYCLE`.
    - Any hit or partial: pick the lowest index in the group, register the result, go to RESP.
    - Otherwise, if this is the last group, register the default result and go to RESP. Else g←g+1.
  - RESP: `resp_valid`=1 and outputs are held stable until `resp_ready`, then go to IDLE.
- Every entry is checked against both the access base and the access end. Base is `req_addr`; end is `req_addr + (1<<req_size) − 1`, computed in `PADDR_BITS+1` bits.
- Entry base is `{pmp_addr_i, 2'b00}`.
- Match rules per mode:
  - OFF (0): never matches.
  - TOR (1): match when prev_base ≤ a < base_i. prev_base is entry i−1's base, or 0 for entry 0.
  - NA4 (2): match when a[PADDR_BITS−1:2] == pmp_addr_i.
  - NAPOT (3): match when ((a ^ base_i) & ~mask_i) == 0.
- Hit: both base and end match. Partial: exactly one of them matches. A partial match is treated as a hit with r=w=x=0 and L ignored.
- On a full hit with `req_prv`>1 and L=0, r=w=x=1 (ignore rule). Otherwise r/w/x come from cfg.
- No hit: r=w=x=(`req_prv`>1), `resp_hit`=0.
- If the end computation carries out, the access faults: r=w=x=0, `resp_allow`=0, `resp_hit`=0, and the scan is skipped (go straight to RESP).
- `resp_allow` selects r, w or x by the latched `req_type`.
- `pmp_*` inputs are sampled live during SCAN. Software must hold them stable while `req_ready`=0; a change mid-scan gives an undefined result.

## Timing
- Reset values: FSM=IDLE, `req_ready`=1, `resp_valid`=0, all `resp_*` outputs 0, g=0.
- Request accepted on edge t. Result at `resp_valid` on edge t+k+1, where k is the number of SCAN cycles. Minimum latency is 2 cycles (hit in group 0, or carry fault); maximum is `NUM_ENTRIES/ENTRIES_PER_CYCLE`+1.
- One request outstanding; no back-to-back overlap. `req_ready` stays 0 from acceptance until the cycle after the response handshake.
- `resp_valid` is held with stable data under backpressure.
- Asserting reset mid-SCAN or mid-RESP drops the request immediately and returns to reset values.

## Structure
- `pmp_pkg`:
  - A-field encoding (OFF/TOR/NA4/NAPOT)
  - cfg bit offsets
  - access-type enum
  - FSM state enum
  - `pmp_result_t` struct {r, w, x, hit, idx}
- Sub-module `pmp_entry_match`: combinational per-entry evaluator, E instances.
  - Inputs: base, end, mode, entry base, prev base, mask.
  - Outputs: hit, partial.
- The top level contains the FSM, the group index counter, the priority encoder within a group, and the response register.

## Test plan
- NAPOT: entry 0 at 0x8000_0000 covering 4 KiB, R=1 W=0 X=0, prv=U. Read 0x8000_0010 size 2 → resp_hit=1, idx=0, allow=1, latency 2. Write to the same address → allow=0.
- Priority across groups (E=2): entry 5 is NA4 at 0x1000 with RWX; entry 7 is TOR 0..0x2000 with R only. Read 0x1000 → idx=5, resp_valid 4 cycles after acceptance.
- Partial: NA4 entry at 0x1000 with RWX. 8-byte read at 0x1000 → hit=1, r=w=x=0, allow=0.
- No match: prv=M → r=w=x=1, hit=0. prv=S → r=w=x=0. Both take the maximum latency of 5 cycles at the defaults.
- Ignore/lock: prv=M on an entry with L=0 and RWX=000 → r=w=x=1. The same entry with L=1 → allow=0.
- Backpressure, then reset: hold `resp_ready`=0 for 10 cycles → outputs stable throughout. Pulse `reset` low mid-SCAN → `resp_valid`=0 and `req_ready`=1 asynchronously. End-address overflow at 0xFFFF_FFFE with size 2 → allow=0, hit=0.
